// File: rtl/mult_div_sequencer.sv
// Iterative multiply/divide engine with its own HI/LO registers and a start/busy/done handshake.
// Optional build macro MD_EARLY_TERM_EN: multiply leaves CALC once the remaining multiplier bits are zero.
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_mult,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_req,
    input  logic             rd_is_hi,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               op_mult;
    logic               res_neg;
    logic               dvd_neg;
    logic               op_dbz;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               calc_last;
    logic               start_skip;

    always_comb begin
        a_neg = ~is_unsigned & a[WIDTH-1];
        b_neg = ~is_unsigned & b[WIDTH-1];
        abs_a = a_neg ? -a : a;
        abs_b = b_neg ? -b : b;
    end

    // Divide keeps the partial remainder in acc's upper half and shifts the
    // dividend out of / quotient bits into the lower half; the divisor lives in mcand.
    always_comb begin
        mul_next  = acc + (mplier[0] ? mcand : '0);
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff      = rem_shift - {1'b0, mcand[WIDTH-1:0]};
        q_bit     = ~diff[WIDTH];
        rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        div_next  = {rem_next, acc[WIDTH-2:0], q_bit};
        prod_fix  = res_neg ? -acc : acc;
        quot_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = dvd_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

`ifdef MD_EARLY_TERM_EN
    assign calc_last  = (cnt == '0) || (op_mult && (mplier[WIDTH-1:1] == '0));
    assign start_skip = is_mult && (abs_b == '0);
`else
    assign calc_last  = (cnt == '0);
    assign start_skip = 1'b0;
`endif

    assign busy  = (state != IDLE);
    assign stall = busy & (rd_req | start);
    assign rdata = rd_is_hi ? hi : lo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            op_mult     <= 1'b0;
            res_neg     <= 1'b0;
            dvd_neg     <= 1'b0;
            op_dbz      <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_mult <= is_mult;
                        res_neg <= a_neg ^ b_neg;
                        dvd_neg <= a_neg;
                        op_dbz  <= ~is_mult & (b == '0);
                        acc     <= is_mult ? '0 : {{WIDTH{1'b0}}, abs_a};
                        mcand   <= is_mult ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                        mplier  <= abs_b;
                        cnt     <= CW'(WIDTH - 1);
                        state   <= start_skip ? FIX : CALC;
                    end
                end
                CALC: begin
                    if (op_mult) begin
                        acc    <= mul_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        acc <= div_next;
                    end
                    cnt <= cnt - 1'b1;
                    if (calc_last) state <= FIX;
                end
                FIX: begin
                    if (op_mult) begin
                        {hi, lo} <= prod_fix;
                    end else begin
                        lo <= op_dbz ? '1 : quot_fix;
                        hi <= rem_fix;
                    end
                    done        <= 1'b1;
                    div_by_zero <= op_dbz;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed corner cases plus randomized
// operations against an arithmetic reference model.
module tb_mult_div_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_mult;
    logic        is_unsigned;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_req;
    logic        rd_is_hi;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_by_zero;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [31:0] last_hi  = '0;
    logic [31:0] last_lo  = '0;
    logic [31:0] corners [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    mult_div_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_mult(is_mult), .is_unsigned(is_unsigned),
        .a(a), .b(b), .rd_req(rd_req), .rd_is_hi(rd_is_hi), .rdata(rdata), .hi(hi), .lo(lo),
        .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact arithmetic on 64-bit integers, latency from the operand magnitude.
    task automatic model(input bit mul, input bit uns, input logic [31:0] ia, input logic [31:0] ib,
                         output logic [31:0] eh, output logic [31:0] el, output bit edz, output int lat);
        logic [63:0] p;
        logic [63:0] ua;
        logic [63:0] ub;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [31:0] mag;
        ua  = {32'b0, ia};
        ub  = {32'b0, ib};
        sa  = longint'($signed(ia));
        sb  = longint'($signed(ib));
        edz = 1'b0;
        lat = 34;
        if (mul) begin
            if (uns) p = ua * ub;
            else     p = sa * sb;
            eh = p[63:32];
            el = p[31:0];
`ifdef MD_EARLY_TERM_EN
            mag = (!uns && sb < 0) ? 32'(-sb) : ib;
            if (mag == 0) lat = 2;
            else for (int i = 0; i < 32; i++) if (mag[i]) lat = i + 3;
`else
            mag = ib;
`endif
        end else begin
            mag = ib;
            if (ib == 0) begin
                el  = 32'hFFFF_FFFF;
                eh  = ia;
                edz = 1'b1;
            end else if (uns) begin
                el = ia / ib;
                eh = ia % ib;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                el = q[31:0];
                eh = r[31:0];
            end
        end
    endtask

    // Starts in the current cycle and returns at the negedge of the done cycle,
    // so consecutive calls issue back-to-back.
    task automatic run_op(input string tag, input bit mul, input bit uns, input logic [31:0] ia,
                          input logic [31:0] ib, input bit rq, input bit rhi, input int poke);
        logic [31:0] eh;
        logic [31:0] el;
        bit          edz;
        int          lat;
        int          cyc;
        model(mul, uns, ia, ib, eh, el, edz, lat);
        start = 1'b1; is_mult = mul; is_unsigned = uns; a = ia; b = ib;
        rd_req = rq; rd_is_hi = rhi;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; is_mult = 1'($urandom); is_unsigned = 1'($urandom);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1 || cyc > 80) break;
            chk({tag, " busy"}, busy, 1);
            chk({tag, " stall"}, stall, rd_req | start);
            chk({tag, " hold_hi"}, hi, last_hi);
            start = (cyc == poke - 1);
        end
        start = 1'b0;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " hi"}, hi, eh);
        chk({tag, " lo"}, lo, el);
        chk({tag, " div_by_zero"}, div_by_zero, edz);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " stall_at_done"}, stall, 0);
        chk({tag, " rdata"}, rdata, rhi ? eh : el);
        last_hi = eh;
        last_lo = el;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle done", done, 0);
            chk("idle busy", busy, 0);
            chk("idle hi", hi, last_hi);
            chk("idle lo", lo, last_lo);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 20));
            1:       return $urandom;
            2:       return corners[$urandom_range(0, 4)];
            default: return -32'($urandom_range(1, 20));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; is_mult = 1'b0; is_unsigned = 1'b0;
        a = '0; b = '0; rd_req = 1'b0; rd_is_hi = 1'b0;
        #3;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", div_by_zero, 0);
        chk("reset hi", hi, 0);
        chk("reset lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_ff_x2", 1, 1, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        run_op("mult_m3_x5", 1, 0, -32'd3, 32'd5, 0, 0, 0);
        run_op("mult_min_sq", 1, 0, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
        idle(2);
        run_op("div_m7_2", 0, 0, -32'd7, 32'd2, 0, 0, 0);
        run_op("div_min_m1", 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
        run_op("divu_5_0", 0, 1, 32'd5, 32'd0, 0, 0, 0);
        run_op("div_neg_0", 0, 0, 32'hFFFF_FFF0, 32'd0, 0, 0, 0);
        idle(1);
        run_op("rd_stall", 0, 0, 32'h1234_5678, 32'h0000_0FED, 1, 1, 5);
        idle(3);
        run_op("multu_7_1", 1, 1, 32'd7, 32'd1, 0, 0, 0);
        run_op("mult_x0", 1, 0, 32'h1234_5678, 32'd0, 0, 0, 0);

        // Reset in the middle of CALC discards the operation and clears HI/LO.
        start = 1'b1; is_mult = 1'b0; is_unsigned = 1'b1; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset hi", hi, 0);
        chk("midreset lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_hi = '0;
        last_lo = '0;
        idle(40);

        for (int i = 0; i < 24; i++) begin
            run_op("random", 1'($urandom), 1'($urandom), pick(), pick(),
                   1'($urandom), 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
